// File: rtl/uart_pkg.sv
// Shared definitions for the serial frame receiver: frame geometry, line
// levels, receiver state encoding and the parity helper.
// Used by: uart_rx_muestreo, uart_receptor.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam int   N_SLOTS     = 4;
  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Even parity over the payload: the parity bit on the line equals this.
  function automatic logic parity(input logic [DATA_BITS-1:0] dat);
    return ^dat;
  endfunction

endpackage

// File: rtl/uart_rx_muestreo.sv
// Line sampler: input synchronizer plus the 4-bit tick counter that decides
// on which iCE pulses the receiver looks at the line.
// Ports: iClk/iReset (async active-low), iCE sample-rate enable, iDato raw
//   line; i_load_vld/i_load_dat reload the tick counter on a sample strobe;
//   o_smp_vld one-cycle sample strobe, o_smp_dat synchronized line level.
module uart_rx_muestreo
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCE,
  input  logic       iDato,
  input  logic       i_load_vld,
  input  logic [3:0] i_load_dat,
  output logic       o_smp_vld,
  output logic       o_smp_dat
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             tick_q, tick_d;

  // The synchronizer runs on every iClk, independent of iCE, so the line
  // delay stays a fixed number of clocks rather than a number of bit ticks.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], iDato};
  end

  // tick_q counts the iCE pulses still to skip before the next sample.
  // A strobe fires on an iCE where it is already zero; the receiver then
  // supplies the next gap, or leaves it at zero (IDLE samples every iCE).
  always_comb begin
    tick_d = tick_q;
    if (iCE) begin
      if (tick_q != 4'd0) begin
        tick_d = tick_q - 4'd1;
      end else if (i_load_vld) begin
        tick_d = i_load_dat;
      end else begin
        tick_d = 4'd0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      tick_q <= 4'd0;
    end else begin
      sync_q <= sync_d;
      tick_q <= tick_d;
    end
  end

  assign o_smp_vld = iCE && (tick_q == 4'd0);
  assign o_smp_dat = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receptor.sv
// Serial frame receiver: rebuilds the four round-robin payload slots from the
// emitter line (start=1, 8 data LSB first, even parity, stop=0, idle=0).
// Ports: iClk, iReset (async active-low), iCE (OVS pulses per bit), iDato;
//   ovCarga0..3 last good byte per slot, oValid/oErrParidad/oErrTrama
//   one-cycle pulses, ovIndex slot of latest frame, ovErrCount error count.
// Build option: UART_RX_ERRCNT_EN enables the saturating error counter;
//   without it ovErrCount is constant zero.
module uart_receptor
  import uart_pkg::*;
#(
  parameter int OVS         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCE,
  input  logic       iDato,
  output logic [7:0] ovCarga0,
  output logic [7:0] ovCarga1,
  output logic [7:0] ovCarga2,
  output logic [7:0] ovCarga3,
  output logic       oValid,
  output logic [1:0] ovIndex,
  output logic       oErrParidad,
  output logic       oErrTrama,
  output logic [7:0] ovErrCount
);

  localparam int         HALF      = OVS / 2;
  localparam logic [3:0] TICK_BIT  = 4'(OVS - 1);
  // Gap from start detection to its mid-bit confirmation, minus the strobe.
  localparam logic [3:0] TICK_HALF = (HALF > 0) ? 4'(HALF - 1) : 4'd0;

  state_t                               state_q, state_d;
  logic [2:0]                           bit_q, bit_d;
  logic [DATA_BITS-1:0]                 shreg_q, shreg_d;
  logic                                 par_q, par_d;
  logic [N_SLOTS-1:0][DATA_BITS-1:0]    carga_q, carga_d;
  logic [1:0]                           idx_q, idx_d;
  logic [1:0]                           slot_q, slot_d;
  logic                                 valid_q, valid_d;
  logic                                 errp_q, errp_d;
  logic                                 errt_q, errt_d;

  logic       smp_vld;
  logic       smp_dat;
  logic       load_vld;
  logic [3:0] load_dat;
  logic       par_ok;
  logic       stop_ok;
  logic       frame_end;

  uart_rx_muestreo #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_muestreo (
    .iClk      (iClk),
    .iReset    (iReset),
    .iCE       (iCE),
    .iDato     (iDato),
    .i_load_vld(load_vld),
    .i_load_dat(load_dat),
    .o_smp_vld (smp_vld),
    .o_smp_dat (smp_dat)
  );

  assign par_ok    = (par_q == parity(shreg_q));
  assign stop_ok   = (smp_dat == IDLE_LEVEL);
  assign frame_end = smp_vld && (state_q == STOP);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    carga_d  = carga_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    valid_d  = 1'b0;
    errp_d   = 1'b0;
    errt_d   = 1'b0;
    load_vld = 1'b0;
    load_dat = TICK_BIT;

    if (smp_vld) begin
      case (state_q)
        IDLE: begin
          if (smp_dat == START_LEVEL) begin
            load_vld = 1'b1;
            if (HALF == 0) begin
              // One sample per bit: the detection sample is the confirmation.
              state_d  = DATA;
              bit_d    = 3'd0;
              load_dat = TICK_BIT;
            end else begin
              state_d  = START;
              load_dat = TICK_HALF;
            end
          end
        end
        START: begin
          if (smp_dat == START_LEVEL) begin
            state_d  = DATA;
            bit_d    = 3'd0;
            load_vld = 1'b1;
            load_dat = TICK_BIT;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shreg_d[bit_q] = smp_dat;
          load_vld       = 1'b1;
          load_dat       = TICK_BIT;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        PARITY: begin
          par_d    = smp_dat;
          load_vld = 1'b1;
          load_dat = TICK_BIT;
          state_d  = STOP;
        end
        STOP: begin
          // No reload: the counter drops back to zero so IDLE samples the
          // very next iCE and back-to-back frames are caught.
          state_d = IDLE;
          valid_d = par_ok && stop_ok;
          errp_d  = !par_ok;
          errt_d  = !stop_ok;
          if (par_ok && stop_ok) begin
            carga_d[slot_q] = shreg_q;
          end
          idx_d  = slot_q;
          slot_d = slot_q + 2'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      carga_q <= '0;
      idx_q   <= 2'd0;
      slot_q  <= 2'd0;
      valid_q <= 1'b0;
      errp_q  <= 1'b0;
      errt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      carga_q <= carga_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      errp_q  <= errp_d;
      errt_q  <= errt_d;
    end
  end

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // One increment per bad frame, even when both error kinds fire together.
  always_comb begin
    errcnt_d = errcnt_q;
    if (frame_end && (!par_ok || !stop_ok) && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      errcnt_q <= 8'h00;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign ovErrCount = errcnt_q;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
  assign ovErrCount       = 8'h00;
`endif

  assign ovCarga0    = carga_q[0];
  assign ovCarga1    = carga_q[1];
  assign ovCarga2    = carga_q[2];
  assign ovCarga3    = carga_q[3];
  assign oValid      = valid_q;
  assign ovIndex     = idx_q;
  assign oErrParidad = errp_q;
  assign oErrTrama   = errt_q;

endmodule

// File: tb/tb_uart_receptor.sv
// Directed bench for uart_receptor: one instance at one sample per bit with
// iCE always high, one at four samples per bit with iCE every other clock.
module tb_uart_receptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef UART_RX_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       r1_n, ce1, d1;
  logic [7:0] c1_0, c1_1, c1_2, c1_3, e1;
  logic       v1, p1, t1;
  logic [1:0] x1;

  logic       r4_n, ce4, d4;
  logic [7:0] c4_0, c4_1, c4_2, c4_3, e4;
  logic       v4, p4, t4;
  logic [1:0] x4;

  uart_receptor #(.OVS(1), .SYNC_STAGES(2)) u1 (
    .iClk(clk), .iReset(r1_n), .iCE(ce1), .iDato(d1),
    .ovCarga0(c1_0), .ovCarga1(c1_1), .ovCarga2(c1_2), .ovCarga3(c1_3),
    .oValid(v1), .ovIndex(x1), .oErrParidad(p1), .oErrTrama(t1),
    .ovErrCount(e1)
  );

  uart_receptor #(.OVS(4), .SYNC_STAGES(3)) u4 (
    .iClk(clk), .iReset(r4_n), .iCE(ce4), .iDato(d4),
    .ovCarga0(c4_0), .ovCarga1(c4_1), .ovCarga2(c4_2), .ovCarga3(c4_3),
    .oValid(v4), .ovIndex(x4), .oErrParidad(p4), .oErrTrama(t4),
    .ovErrCount(e4)
  );

  int checks = 0;
  int errors = 0;

  // Cycles each pulse output was seen high; a 1-cycle pulse adds exactly 1.
  int nv1 = 0, np1 = 0, nt1 = 0, nv4 = 0, np4 = 0, nt4 = 0;
  always @(negedge clk) begin
    if (v1) nv1++;
    if (p1) np1++;
    if (t1) nt1++;
    if (v4) nv4++;
    if (p4) np4++;
    if (t4) nt4++;
  end

  function automatic logic [7:0] ecnt(input int n);
    if (!CNT_EN) return 8'h00;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic bit1(input logic b);
    @(negedge clk);
    d1 = b;
  endtask

  task automatic send1(input logic [7:0] dat, input logic par, input logic stp, input int tail);
    bit1(1'b1);
    for (int i = 0; i < 8; i++) bit1(dat[i]);
    bit1(par);
    bit1(stp);
    for (int i = 0; i < tail; i++) bit1(1'b0);
  endtask

  task automatic ice4(input logic b);
    @(negedge clk);
    d4  = b;
    ce4 = 1'b1;
    @(negedge clk);
    ce4 = 1'b0;
  endtask

  task automatic bit4(input logic b);
    repeat (4) ice4(b);
  endtask

  task automatic send4(input logic [7:0] dat, input logic par, input logic stp, input int tail);
    bit4(1'b1);
    for (int i = 0; i < 8; i++) bit4(dat[i]);
    bit4(par);
    bit4(stp);
    for (int i = 0; i < tail; i++) bit4(1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({c1_0, c1_1, c1_2, c1_3} !== 32'h0) begin errors++; $display("FAIL reset_carga1: got %h expected 0", {c1_0, c1_1, c1_2, c1_3}); end
    checks++; if ({v1, p1, t1, x1} !== 5'b0) begin errors++; $display("FAIL reset_flags1: got %b expected 00000", {v1, p1, t1, x1}); end
    checks++; if (e1 !== 8'h00) begin errors++; $display("FAIL reset_errcnt1: got %h expected 00", e1); end
    checks++; if ({c4_0, c4_1, c4_2, c4_3} !== 32'h0) begin errors++; $display("FAIL reset_carga4: got %h expected 0", {c4_0, c4_1, c4_2, c4_3}); end
    checks++; if ({v4, p4, t4, x4, e4} !== 13'b0) begin errors++; $display("FAIL reset_flags4: got %b expected 0", {v4, p4, t4, x4, e4}); end
    @(negedge clk);
    r1_n = 1'b1;
    r4_n = 1'b1;
    ce1  = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_frame;
    int bv, bp, bt;
    bv = nv1; bp = np1; bt = nt1;
    send1(8'hA5, 1'b0, 1'b0, 2);
    repeat (5) bit1(1'b0);
    checks++; if (c1_0 !== 8'hA5) begin errors++; $display("FAIL good_carga0: got %h expected a5", c1_0); end
    checks++; if (nv1 - bv !== 1) begin errors++; $display("FAIL good_valid_cycles: got %0d expected 1", nv1 - bv); end
    checks++; if ((np1 - bp) + (nt1 - bt) !== 0) begin errors++; $display("FAIL good_no_err: got %0d expected 0", (np1 - bp) + (nt1 - bt)); end
    checks++; if (x1 !== 2'd0) begin errors++; $display("FAIL good_index: got %0d expected 0", x1); end
  endtask

  task automatic test_parity_err;
    int bv, bp;
    bv = nv1; bp = np1;
    send1(8'h3C, 1'b1, 1'b0, 2);
    repeat (5) bit1(1'b0);
    checks++; if (np1 - bp !== 1) begin errors++; $display("FAIL par_pulse: got %0d expected 1", np1 - bp); end
    checks++; if (nv1 - bv !== 0) begin errors++; $display("FAIL par_no_valid: got %0d expected 0", nv1 - bv); end
    checks++; if (c1_1 !== 8'h00) begin errors++; $display("FAIL par_carga1: got %h expected 00", c1_1); end
    checks++; if (x1 !== 2'd1) begin errors++; $display("FAIL par_index: got %0d expected 1", x1); end
    checks++; if (e1 !== ecnt(1)) begin errors++; $display("FAIL par_errcnt: got %h expected %h", e1, ecnt(1)); end
  endtask

  task automatic test_frame_err;
    int bv, bp, bt;
    bv = nv1; bp = np1; bt = nt1;
    send1(8'h0F, 1'b0, 1'b1, 2);
    repeat (5) bit1(1'b0);
    checks++; if (nt1 - bt !== 1) begin errors++; $display("FAIL trama_pulse: got %0d expected 1", nt1 - bt); end
    checks++; if ((np1 - bp) + (nv1 - bv) !== 0) begin errors++; $display("FAIL trama_other: got %0d expected 0", (np1 - bp) + (nv1 - bv)); end
    checks++; if (c1_2 !== 8'h00) begin errors++; $display("FAIL trama_carga2: got %h expected 00", c1_2); end
    checks++; if (x1 !== 2'd2) begin errors++; $display("FAIL trama_index: got %0d expected 2", x1); end
    send1(8'h5A, 1'b0, 1'b0, 2);
    repeat (5) bit1(1'b0);
    checks++; if (c1_3 !== 8'h5A) begin errors++; $display("FAIL slot3_carga3: got %h expected 5a", c1_3); end
    checks++; if (x1 !== 2'd3) begin errors++; $display("FAIL slot3_index: got %0d expected 3", x1); end
    checks++; if (e1 !== ecnt(2)) begin errors++; $display("FAIL trama_errcnt: got %h expected %h", e1, ecnt(2)); end
  endtask

  task automatic test_both_err;
    int bp, bt;
    bp = np1; bt = nt1;
    send1(8'h01, 1'b0, 1'b1, 2);
    repeat (5) bit1(1'b0);
    checks++; if ({np1 - bp, nt1 - bt} !== {32'sd1, 32'sd1}) begin errors++; $display("FAIL both_pulses: got par %0d trama %0d expected 1 1", np1 - bp, nt1 - bt); end
    checks++; if (x1 !== 2'd0) begin errors++; $display("FAIL both_index_wrap: got %0d expected 0", x1); end
    checks++; if (c1_0 !== 8'hA5) begin errors++; $display("FAIL both_carga0_kept: got %h expected a5", c1_0); end
    checks++; if (e1 !== ecnt(3)) begin errors++; $display("FAIL both_errcnt_once: got %h expected %h", e1, ecnt(3)); end
  endtask

  task automatic test_false_start;
    int bv, bp, bt;
    bv = nv4; bp = np4; bt = nt4;
    ice4(1'b1);
    repeat (20) ice4(1'b0);
    checks++; if ((nv4 - bv) + (np4 - bp) + (nt4 - bt) !== 0) begin errors++; $display("FAIL false_start_pulses: got %0d expected 0", (nv4 - bv) + (np4 - bp) + (nt4 - bt)); end
    checks++; if (x4 !== 2'd0) begin errors++; $display("FAIL false_start_index: got %0d expected 0", x4); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [5];
    int bv, be;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bv = nv4; be = np4 + nt4;
    for (int i = 0; i < 5; i++) send4(bytes[i], ^bytes[i], 1'b0, 2);
    repeat (4) ice4(1'b0);
    checks++; if ({c4_0, c4_1, c4_2, c4_3} !== 32'h55223344) begin errors++; $display("FAIL b2b_cargas: got %h expected 55223344", {c4_0, c4_1, c4_2, c4_3}); end
    checks++; if (x4 !== 2'd0) begin errors++; $display("FAIL b2b_index: got %0d expected 0", x4); end
    checks++; if (nv4 - bv !== 5) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 5", nv4 - bv); end
    checks++; if ((np4 + nt4) - be !== 0) begin errors++; $display("FAIL b2b_no_err: got %0d expected 0", (np4 + nt4) - be); end
  endtask

  task automatic test_reset_mid;
    int bv;
    bit4(1'b1);
    for (int i = 0; i < 4; i++) bit4(1'b1);
    repeat (2) ice4(1'b0);
    @(negedge clk);
    #2 r4_n = 1'b0;
    #1;
    checks++; if ({c4_0, c4_1, c4_2, c4_3} !== 32'h0) begin errors++; $display("FAIL rmid_cargas: got %h expected 0", {c4_0, c4_1, c4_2, c4_3}); end
    checks++; if ({v4, p4, t4, x4, e4} !== 13'b0) begin errors++; $display("FAIL rmid_flags: got %b expected 0", {v4, p4, t4, x4, e4}); end
    @(negedge clk);
    d4 = 1'b0;
    @(negedge clk);
    r4_n = 1'b1;
    repeat (4) ice4(1'b0);
    bv = nv4;
    send4(8'h81, 1'b0, 1'b0, 2);
    repeat (4) ice4(1'b0);
    checks++; if (c4_0 !== 8'h81) begin errors++; $display("FAIL rmid_carga0: got %h expected 81", c4_0); end
    checks++; if ({x4, c4_1} !== 10'h0) begin errors++; $display("FAIL rmid_index_carga1: got %h expected 0", {x4, c4_1}); end
    checks++; if (nv4 - bv !== 1) begin errors++; $display("FAIL rmid_valid: got %0d expected 1", nv4 - bv); end
  endtask

  task automatic test_err_sat;
`ifdef UART_RX_ERRCNT_EN
    repeat (249) send1(8'h3C, 1'b1, 1'b0, 1);
    repeat (5) bit1(1'b0);
    checks++; if (e1 !== 8'd252) begin errors++; $display("FAIL errcnt_mid: got %0d expected 252", e1); end
    repeat (51) send1(8'h3C, 1'b1, 1'b0, 1);
    repeat (5) bit1(1'b0);
    checks++; if (e1 !== 8'hFF) begin errors++; $display("FAIL errcnt_sat: got %h expected ff", e1); end
`else
    repeat (3) send1(8'h3C, 1'b1, 1'b0, 1);
    repeat (5) bit1(1'b0);
    checks++; if (e1 !== 8'h00) begin errors++; $display("FAIL errcnt_off: got %h expected 00", e1); end
`endif
  endtask

  initial begin
    r1_n = 1'b0; r4_n = 1'b0;
    ce1  = 1'b0; ce4  = 1'b0;
    d1   = 1'b0; d4   = 1'b0;
    test_reset;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_both_err;
    test_false_start;
    test_back_to_back;
    test_reset_mid;
    test_err_sat;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receptor.md
Name: uart_receptor

Overview:
Serial frame receiver directly downstream of the round-robin serial emitter; consumes its single-bit line and rebuilds the four 8-bit payload slots.
- Frame, one bit-time each: start=1, D0..D7 LSB first, even parity (XOR of D0..D7), stop bits=0; idle line=0.
- Emitter sends slots 0,1,2,3 cyclically with no slot marker, so the slot number comes from a local frame counter.
- Outputs feed the register bank / display logic.

Parameters:
- OVS, 4, iCE pulses per bit-time (1..16); OVS=1 means one sample per bit.
- SYNC_STAGES, 2, input synchronizer depth (2..3).

Ports:
- iClk  in  1  system clock.
- iReset  in  1  reset; asynchronous, active-low.
- iCE  in  1  sample-rate enable; OVS pulses per emitter bit-time.
- iDato  in  1  serial line from emitter.
- ovCarga0..ovCarga3  out  8 each  last good byte per slot.
- oValid  out  1  one-iClk pulse per accepted frame.
- ovIndex  out  2  slot of the most recent frame, good or bad.
- oErrParidad  out  1  one-iClk pulse on parity mismatch.
- oErrTrama  out  1  one-iClk pulse on stop bit read as 1.
- ovErrCount  out  8  error counter (see Optional Feature).

Behaviour:
- Reset (iReset=0, async) clears:
  - all ovCarga to 0x00; ovIndex, slot counter, ovErrCount to 0;
  - oValid, oErrParidad, oErrTrama to 0;
  - synchronizer flops to 0 (idle level); state to IDLE.
  - Reset mid-frame aborts the frame; the next frame is slot 0.
- iDato passes through SYNC_STAGES flops. All sampling is on the synchronized value, and only on iClk edges where iCE=1.
- Tick counter is 4 bits wide. The bit counter counts 0..7.
- States:
  - IDLE: on a sampled 1, load tick=OVS/2 (integer) and go to START.
  - START: decrement tick each iCE. At tick==0 sample the line: 1 → reload tick=OVS-1, bit=0, go to DATA; 0 → false start, back to IDLE with no outputs. With OVS=1 the confirmation happens on the detection sample itself.
  - DATA: at each tick==0 shift the sample into bit position bit (LSB first) and reload tick=OVS-1. After bit 7, go to PARITY.
  - PARITY: at tick==0 capture the parity sample and go to STOP.
  - STOP: at tick==0 sample the stop bit and go to IDLE. Evaluate the frame on the same edge (next bullet).
- Frame evaluation, on the STOP-sample edge:
  - Good frame = parity sample equals XOR(data) and stop==0.
    - Write ovCarga[slot] and pulse oValid.
  - Parity bad: pulse oErrParidad; ovCarga unchanged.
  - Stop==1: pulse oErrTrama; ovCarga unchanged.
  - Both errors may pulse together.
  - In every case: ovIndex<=slot, then slot<=slot+1 (wraps 3→0).
- Pulses are exactly one iClk cycle wide, even when iCE is held high.
- Back-to-back frames: IDLE re-arms on the edge after the stop sample. The emitter's 3 trailing zeros give margin; one zero stop bit is sufficient.
- iCE=0 freezes all state. Pulses still deassert on the next edge.

Optional Feature:
- Macro: UART_RX_ERRCNT_EN.
- Defined: ovErrCount increments on every frame with oErrParidad or oErrTrama, counting once even if both fire. It saturates at 0xFF and clears only on reset.
- Not defined: ovErrCount tied to 0x00 and no counter flops exist. The port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - DATA_BITS=8, N_SLOTS=4, IDLE_LEVEL=1'b0, START_LEVEL=1'b1;
  - the state typedef {IDLE, START, DATA, PARITY, STOP};
  - a parity function (XOR reduce).
- One sub-module, uart_rx_muestreo: synchronizer plus tick counter. It outputs a one-cycle sample strobe and the synchronized bit. The FSM and slot bank stay in uart_receptor.

Test Plan:
- OVS=1, iCE=1 constantly; drive frame 1,1,0,1,0,0,1,0,1,0,0,0,0 (0xA5, parity 0) → ovCarga0=0xA5, one oValid pulse, ovIndex=0, next slot 1, no error pulses.
- Next frame 0x3C with parity bit 1 (correct is 0) → oErrParidad pulse, ovCarga1 stays 0x00, ovIndex=1. With the macro defined, ovErrCount=1.
- Frame 0x0F with correct parity 0 and stop bit 1 → oErrTrama pulse, ovCarga2 unchanged, slot advances to 3.
- OVS=4: line high for 1 iCE, then low for 20 iCE → no pulses, state IDLE. Then send frames 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back with 3 stop zeros each → ovCarga0..3 = 0x55, 0x22, 0x33, 0x44; ovIndex=0 after the fifth frame.
- Assert iReset=0 asynchronously during D4 of a frame → all outputs 0 immediately. Release, then send 0x81 (parity 0) → lands in ovCarga0.
- Macro defined: force 300 parity-error frames → ovErrCount saturates at 0xFF.
